// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_DATA   = 3'd3,
        RX_ACK    = 3'd4,
        TX_DATA   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic I2C_ACK       = 1'b0;
    localparam logic I2C_NACK      = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one bus line plus a previous-value flop for edge detection.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Preset to 1 (idle bus) so leaving reset never fakes a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            sync_p0 <= line;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~prev_p2;
    assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target: START/STOP detection, 7-bit address match, byte receive with ACK and byte transmit.
module i2c_slave_core
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h67
) (
    input  logic       i2c_core_clk_i,
    input  logic       i2c_rst_i,
    input  logic       i2c_scl_i,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_en_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_req_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       nack_o,
    output logic       busy_o
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE);
    localparam logic [3:0] ACK_BIT  = 4'(BITS_PER_BYTE + 1);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk   (i2c_core_clk_i),
        .rst   (i2c_rst_i),
        .line  (i2c_scl_i),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (i2c_core_clk_i),
        .rst   (i2c_rst_i),
        .line  (i2c_sda_i),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_t state;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       start_det;
    logic       stop_det;
    logic [7:0] load_byte;

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;
    assign load_byte = tx_valid_i ? tx_data_i : 8'hFF;
    assign i2c_sda_o = 1'b0;

    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_rst_i) begin
            state        <= IDLE;
            shift        <= 8'h00;
            bit_cnt      <= 4'd0;
            rw           <= 1'b0;
            i2c_sda_en_o <= 1'b0;
            tx_req_o     <= 1'b0;
            rx_data_o    <= 8'h00;
            rx_valid_o   <= 1'b0;
            nack_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            tx_req_o   <= 1'b0;
            nack_o     <= 1'b0;
            if (start_det) begin
                state        <= ADDR;
                bit_cnt      <= 4'd0;
                i2c_sda_en_o <= 1'b0;
                busy_o       <= 1'b1;
            end else if (stop_det) begin
                state        <= IDLE;
                bit_cnt      <= 4'd0;
                i2c_sda_en_o <= 1'b0;
                busy_o       <= 1'b0;
            end else if (scl_rise) begin
                if (state != IDLE && state != WAIT_STOP)
                    bit_cnt <= bit_cnt + 4'd1;
                case (state)
                    ADDR, RX_DATA: shift <= {shift[6:0], sda_level};
                    ADDR_ACK:      if (rw) tx_req_o <= 1'b1;
                    TX_ACK: begin
                        if (sda_level == I2C_ACK) begin
                            tx_req_o <= 1'b1;
                        end else begin
                            nack_o <= 1'b1;
                            state  <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ADDR: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (shift[7:1] == SLAVE_ADDR) begin
                                i2c_sda_en_o <= 1'b1;
                                rw           <= shift[0];
                                state        <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK, TX_ACK: begin
                        if (bit_cnt == ACK_BIT) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR_ACK && !rw) begin
                                i2c_sda_en_o <= 1'b0;
                                state        <= RX_DATA;
                            end else begin
                                shift        <= load_byte;
                                i2c_sda_en_o <= ~load_byte[7];
                                state        <= TX_DATA;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            rx_data_o    <= shift;
                            rx_valid_o   <= 1'b1;
                            i2c_sda_en_o <= 1'b1;
                            state        <= RX_ACK;
                        end
                    end
                    RX_ACK: begin
                        if (bit_cnt == ACK_BIT) begin
                            bit_cnt      <= 4'd0;
                            i2c_sda_en_o <= 1'b0;
                            state        <= RX_DATA;
                        end
                    end
                    TX_DATA: begin
                        // Bit 7 went out at load; each later fall presents the next bit down.
                        if (bit_cnt == LAST_BIT) begin
                            i2c_sda_en_o <= 1'b0;
                            state        <= TX_ACK;
                        end else if (bit_cnt != 4'd0) begin
                            shift        <= shift << 1;
                            i2c_sda_en_o <= ~shift[6];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-banged master on a wired-AND SDA, scoreboard queues for RX/TX bytes.
module tb_i2c_slave_core;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_o;
    logic       sda_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       nack;
    logic       busy;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_en;

    i2c_slave_core #(.SLAVE_ADDR(7'h67)) dut (
        .i2c_core_clk_i (clk),
        .i2c_rst_i      (rst),
        .i2c_scl_i      (scl_m),
        .i2c_sda_i      (sda_bus),
        .i2c_sda_o      (sda_o),
        .i2c_sda_en_o   (sda_en),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_req_o       (tx_req),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .nack_o         (nack),
        .busy_o         (busy)
    );

    int checks = 0;
    int passed = 0;
    int rx_cnt = 0;
    int txreq_cnt = 0;
    int nack_cnt = 0;
    logic sda_en_seen = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    logic prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Output monitor: pops the RX scoreboard and polices the single-cycle pulse outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (sda_en) sda_en_seen = 1'b1;
            if (rx_valid || tx_req || nack) begin
                check("pulse_excl", 32'(rx_valid) + 32'(tx_req) + 32'(nack), 32'd1);
                check("pulse_width", {31'd0, prev_pulse}, 32'd0);
            end
            prev_pulse = rx_valid | tx_req | nack;
            if (tx_req) txreq_cnt++;
            if (nack) nack_cnt++;
            if (rx_valid) begin
                rx_cnt++;
                if (rx_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else check("rx_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
            end
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        sda_m = 1'b0; wait_clks(2 * Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        scl_m = 1'b0; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        sda_m = 1'b1; wait_clks(2 * Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;    wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        s = sda_bus;  wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic set_tx(input logic [7:0] d, input logic v);
        tx_data  = d;
        tx_valid = v;
        tx_exp.push_back(v ? d : 8'hFF);
    endtask

    task automatic read_byte(input logic mack, input logic load_next, input logic [7:0] nd,
                             input logic nv, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        sda_m = mack; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        if (load_next) set_tx(nd, nv);
        wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic check_tx(input string name, input logic [7:0] d);
        if (tx_exp.size() == 0) check(name, {24'd0, d}, 32'hFFFF_FFFF);
        else check(name, {24'd0, d}, {24'd0, tx_exp.pop_front()});
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nbytes;
        logic       match;
    } wr_vec_t;

    wr_vec_t vecs[5];

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         rx_before;
        int         req_before;
        int         nack_before;

        vecs[0] = '{8'hCE, 8'h31, 8'h1D, 2, 1'b1};
        vecs[1] = '{8'hAA, 8'h31, 8'h00, 1, 1'b0};
        vecs[2] = '{8'hCE, 8'h00, 8'hFF, 2, 1'b1};
        vecs[3] = '{8'hCC, 8'h5A, 8'h00, 1, 1'b0};
        vecs[4] = '{8'hCE, 8'h80, 8'h01, 2, 1'b1};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        wait_clks(4);
        check("reset_outputs", {sda_en, tx_req, rx_valid, nack, busy, sda_o}, 6'b0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        wait_clks(4);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Write / address-mismatch vectors
        for (int v = 0; v < 5; v++) begin
            rx_before   = rx_cnt;
            sda_en_seen = 1'b0;
            i2c_start();
            check("start_busy", {31'd0, busy}, 32'd1);
            write_byte(vecs[v].addr, ack);
            check("addr_ack", {31'd0, ack}, {31'd0, ~vecs[v].match});
            if (vecs[v].match) rx_q.push_back(vecs[v].d0);
            write_byte(vecs[v].d0, ack);
            check("data0_ack", {31'd0, ack}, {31'd0, ~vecs[v].match});
            if (vecs[v].nbytes > 1) begin
                if (vecs[v].match) rx_q.push_back(vecs[v].d1);
                write_byte(vecs[v].d1, ack);
                check("data1_ack", {31'd0, ack}, {31'd0, ~vecs[v].match});
            end
            check("busy_before_stop", {31'd0, busy}, 32'd1);
            i2c_stop();
            check("busy_after_stop", {31'd0, busy}, 32'd0);
            check("rx_count", rx_cnt - rx_before, vecs[v].match ? vecs[v].nbytes : 0);
            if (!vecs[v].match) check("mismatch_no_drive", {31'd0, sda_en_seen}, 32'd0);
        end

        // Read two bytes: ACK the first, NACK the second
        req_before = txreq_cnt; nack_before = nack_cnt;
        set_tx(8'hA5, 1'b1);
        i2c_start();
        write_byte(8'hCF, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b0, 1'b1, 8'h3C, 1'b1, d);
        check_tx("rd_byte0", d);
        read_byte(1'b1, 1'b0, 8'h00, 1'b0, d);
        check_tx("rd_byte1", d);
        check("rd_sda_released", {31'd0, sda_en}, 32'd0);
        i2c_stop();
        check("rd_tx_req_count", txreq_cnt - req_before, 32'd2);
        check("rd_nack_count", nack_cnt - nack_before, 32'd1);
        check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

        // Read with no valid TX data: 0xFF and no drive during data bits
        req_before = txreq_cnt; nack_before = nack_cnt;
        set_tx(8'h12, 1'b0);
        i2c_start();
        write_byte(8'hCF, ack);
        check("ff_addr_ack", {31'd0, ack}, 32'd0);
        sda_en_seen = 1'b0;
        read_byte(1'b1, 1'b0, 8'h00, 1'b0, d);
        check_tx("ff_byte", d);
        check("ff_no_drive", {31'd0, sda_en_seen}, 32'd0);
        i2c_stop();
        check("ff_tx_req_count", txreq_cnt - req_before, 32'd1);
        check("ff_nack_count", nack_cnt - nack_before, 32'd1);

        // Repeated START: write then read without an intervening STOP
        rx_before = rx_cnt;
        i2c_start();
        write_byte(8'hCE, ack);
        check("sr_waddr_ack", {31'd0, ack}, 32'd0);
        rx_q.push_back(8'h10);
        write_byte(8'h10, ack);
        check("sr_wdata_ack", {31'd0, ack}, 32'd0);
        set_tx(8'h77, 1'b1);
        i2c_start();
        check("sr_busy", {31'd0, busy}, 32'd1);
        write_byte(8'hCF, ack);
        check("sr_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, 1'b0, 8'h00, 1'b0, d);
        check_tx("sr_rd_byte", d);
        i2c_stop();
        check("sr_rx_count", rx_cnt - rx_before, 32'd1);

        // Reset while the slave is driving a 0 data bit
        rx_before = rx_cnt;
        tx_data = 8'h00; tx_valid = 1'b1;
        i2c_start();
        write_byte(8'hCF, ack);
        check("rst_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
        check("rst_pre_drive", {31'd0, sda_en}, 32'd1);
        rst = 1'b1;
        wait_clks(1);
        check("rst_sda_released", {31'd0, sda_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        sda_en_seen = 1'b0;
        for (int i = 0; i < 6; i++) clk_bit(1'b1, s);
        i2c_stop();
        check("rst_no_drive_after", {31'd0, sda_en_seen}, 32'd0);
        check("rst_no_rx", rx_cnt - rx_before, 32'd0);
        check("rst_busy_idle", {31'd0, busy}, 32'd0);
        i2c_start();
        write_byte(8'hCE, ack);
        check("recover_addr_ack", {31'd0, ack}, 32'd0);
        rx_q.push_back(8'h5A);
        write_byte(8'h5A, ack);
        i2c_stop();
        check("recover_rx_count", rx_cnt - rx_before, 32'd1);

        wait_clks(4);
        check("rx_queue_drained", rx_q.size(), 32'd0);
        check("tx_queue_drained", tx_exp.size(), 32'd0);
        check("sda_o_const", {31'd0, sda_o}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
